// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
// REGFILE_BANK_EN adds IRQ shadow copies of R13/R14.
package regfile_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 4;
    localparam int NREGS_DEF   = 15;
    localparam logic [3:0] PC_ADDR = 4'hF;
    localparam int R13_IDX     = 13;
    localparam int R14_IDX     = 14;
`ifdef REGFILE_BANK_EN
    localparam int BANK_EXTRA  = 2;
`else
    localparam int BANK_EXTRA  = 0;
`endif
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per physical register: set by load claim, cleared by load writeback.
// A claim and a clear of the same register in one cycle leave it busy.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NPHYS = 15,
    parameter int PW    = 4,
    parameter int NRD   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    claim_i,
    input  logic [PW-1:0]           claim_idx_i,
    input  logic                    clr_i,
    input  logic [PW-1:0]           clr_idx_i,
    input  logic [NRD-1:0][PW-1:0]  rd_idx_i,
    input  logic [NRD-1:0]          rd_pc_i,
    output logic [NRD-1:0]          rd_busy_o
);
    logic [NPHYS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i && clr_idx_i < PW'(NPHYS))
            busy_d[clr_idx_i] = 1'b0;
        if (claim_i && claim_idx_i < PW'(NPHYS))
            busy_d[claim_idx_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // A load landing this cycle is forwarded by the bypass, so it must not stall.
    always_comb begin
        rd_busy_o = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!rd_pc_i[i] && rd_idx_i[i] < PW'(NPHYS))
                rd_busy_o[i] = busy_q[rd_idx_i[i]] &&
                               !(clr_i && clr_idx_i == rd_idx_i[i]);
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port ARM register file: NRD bypassed read ports, ALU and load write
// ports, load scoreboard, R15 writes turned into a branch request. Option: REGFILE_BANK_EN.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NRD    = 3,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic [DATA_W-1:0]     r15,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  claim,
    input  logic [ADDR_W-1:0]     claim_addr,
    output logic                  br_valid,
    output logic [DATA_W-1:0]     br_target,
    input  logic                  irq_mode
);
    localparam int NPHYS = NREGS + BANK_EXTRA;
    localparam int PW    = $clog2(NPHYS + 1);
    localparam logic [ADDR_W-1:0] PC = '1;

    // Architectural address to physical slot; shadow R13/R14 live above NREGS.
`ifdef REGFILE_BANK_EN
    function automatic logic [PW-1:0] phys(input logic [ADDR_W-1:0] a, input logic irq);
        if (irq && (a == ADDR_W'(R13_IDX) || a == ADDR_W'(R14_IDX)))
            return PW'(a) - PW'(R13_IDX) + PW'(NREGS);
        return PW'(a);
    endfunction
`else
    function automatic logic [PW-1:0] phys(input logic [ADDR_W-1:0] a, input logic irq);
        logic unused_irq;
        unused_irq = irq;
        return PW'(a);
    endfunction
`endif

    logic [NRD-1:0][ADDR_W-1:0] ra_a;
    logic [NRD-1:0][DATA_W-1:0] rd_a;
    logic [NRD-1:0][PW-1:0]     rphys;
    logic [NRD-1:0]             rpc;
    logic [NPHYS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic              br_valid_q, br_valid_d;
    logic [DATA_W-1:0] br_target_q, br_target_d;
    logic [PW-1:0]     p0, p1;
    logic              wr0, wr1, pcw0, pcw1;

    assign ra_a = ra;
    assign rd   = rd_a;
    assign p0   = phys(wa0, irq_mode);
    assign p1   = phys(wa1, irq_mode);
    assign wr0  = we0 && wa0 != PC;
    assign wr1  = we1 && wa1 != PC;
    assign pcw0 = we0 && wa0 == PC;
    assign pcw1 = we1 && wa1 == PC;

    always_comb begin
        rd_a  = '0;
        rphys = '0;
        rpc   = '0;
        for (int i = 0; i < NRD; i++) begin
            rphys[i] = phys(ra_a[i], irq_mode);
            rpc[i]   = ra_a[i] == PC;
            if (rpc[i])                       rd_a[i] = r15;
            else if (wr1 && p1 == rphys[i])   rd_a[i] = wd1;
            else if (wr0 && p0 == rphys[i])   rd_a[i] = wd0;
            else if (rphys[i] < PW'(NPHYS))   rd_a[i] = regs_q[rphys[i]];
        end
    end

    // Load port is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (wr0 && p0 < PW'(NPHYS)) regs_d[p0] = wd0;
        if (wr1 && p1 < PW'(NPHYS)) regs_d[p1] = wd1;
        br_valid_d  = pcw0 || pcw1;
        br_target_d = pcw1 ? wd1 : (pcw0 ? wd0 : br_target_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '0;
            br_valid_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            regs_q      <= regs_d;
            br_valid_q  <= br_valid_d;
            br_target_q <= br_target_d;
        end
    end

    assign br_valid  = br_valid_q;
    assign br_target = br_target_q;

    regfile_scoreboard #(.NPHYS(NPHYS), .PW(PW), .NRD(NRD)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .claim_i     (claim && claim_addr != PC),
        .claim_idx_i (phys(claim_addr, irq_mode)),
        .clr_i       (wr1),
        .clr_idx_i   (p1),
        .rd_idx_i    (rphys),
        .rd_pc_i     (rpc),
        .rd_busy_o   (rd_busy)
    );

`ifndef SYNTHESIS
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return a == PC || int'(a) < NREGS;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!we0 || legal(wa0)) else $error("illegal wa0 %0d", wa0);
            assert (!we1 || legal(wa1)) else $error("illegal wa1 %0d", wa1);
            assert (!claim || legal(claim_addr)) else $error("illegal claim_addr %0d", claim_addr);
            for (int i = 0; i < NRD; i++)
                assert (legal(ra_a[i])) else $error("illegal ra[%0d] %0d", i, ra_a[i]);
        end
    end
`endif
endmodule
